// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: state codes, opcodes,
// ALU-control codes and datapath mux selects, plus the DECODE dispatch rule.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_RTYPE_EX = 4'd6,
      S_RTYPE_WB = 4'd7,
      S_BEQ      = 4'd8,
      S_JUMP     = 4'd9,
      S_ADDI_EX  = 4'd10,
      S_ADDI_WB  = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Unsupported opcodes return S_FETCH, which doubles as the illegal-op flag.
   function automatic state_t decode_next(input logic [5:0] op);
      case (op)
         OP_RTYPE:     return S_RTYPE_EX;
         OP_LW, OP_SW: return S_MEMADR;
         OP_BEQ:       return S_BEQ;
         OP_J:         return S_JUMP;
         OP_ADDI:      return S_ADDI_EX;
         default:      return S_FETCH;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control: Moore FSM, 3-5 cycles per instruction, stretched by
// mem_ready wait states in FETCH/MEMRD/MEMWR; strobes gated to 0 while reset is high.
module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter bit MEM_WAIT_EN = 1'b1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       MemtoReg,
   output logic       IRWrite,
   output logic [1:0] PCSource,
   output logic [1:0] ALUOP,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       RegWrite,
   output logic       RegDst,
   output logic [3:0] state,
   output logic       instr_done,
   output logic       illegal_op
);

   state_t cur;
   logic   rdy;
   logic   op_ok;

   assign rdy   = MEM_WAIT_EN ? mem_ready : 1'b1;
   assign op_ok = (decode_next(opcode) != S_FETCH);
   assign state = cur;

   always_ff @(posedge clock) begin
      if (reset) begin
         cur <= S_FETCH;
      end else begin
         case (cur)
            S_FETCH:    if (rdy) cur <= S_DECODE;
            S_DECODE:   cur <= decode_next(opcode);
            S_MEMADR:   cur <= (opcode == OP_LW) ? S_MEMRD :
                               (opcode == OP_SW) ? S_MEMWR : S_FETCH;
            S_MEMRD:    if (rdy) cur <= S_MEMWB;
            S_MEMWR:    if (rdy) cur <= S_FETCH;
            S_RTYPE_EX: cur <= S_RTYPE_WB;
            S_ADDI_EX:  cur <= S_ADDI_WB;
            // Single-cycle terminal states and unused codes all return to FETCH.
            default:    cur <= S_FETCH;
         endcase
      end
   end

   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      MemtoReg    = 1'b0;
      IRWrite     = 1'b0;
      PCSource    = PCSRC_ALU;
      ALUOP       = ALUOP_ADD;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_RT;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
      case (cur)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = SRCB_FOUR;
            PCWrite = rdy;
            IRWrite = rdy;
         end
         S_DECODE: begin
            ALUSrcB    = SRCB_IMMSH2;
            illegal_op = !op_ok;
            instr_done = !op_ok;
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         S_MEMWB: begin
            RegWrite   = 1'b1;
            MemtoReg   = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWR: begin
            IorD       = 1'b1;
            MemWrite   = 1'b1;
            instr_done = rdy;
         end
         S_RTYPE_EX: begin
            ALUSrcA = 1'b1;
            ALUOP   = ALUOP_FUNCT;
         end
         S_RTYPE_WB: begin
            RegWrite   = 1'b1;
            RegDst     = 1'b1;
            instr_done = 1'b1;
         end
         S_BEQ: begin
            ALUSrcA     = 1'b1;
            ALUOP       = ALUOP_SUB;
            PCWriteCond = 1'b1;
            PCSource    = PCSRC_ALUOUT;
            instr_done  = 1'b1;
         end
         S_JUMP: begin
            PCWrite    = 1'b1;
            PCSource   = PCSRC_JUMP;
            instr_done = 1'b1;
         end
         S_ADDI_EX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = SRCB_IMM;
         end
         S_ADDI_WB: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         default: ;
      endcase
      // An aborted instruction must not write anything on the reset edge.
      if (reset) begin
         PCWrite     = 1'b0;
         PCWriteCond = 1'b0;
         MemRead     = 1'b0;
         MemWrite    = 1'b0;
         IRWrite     = 1'b0;
         RegWrite    = 1'b0;
         instr_done  = 1'b0;
         illegal_op  = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboarded bench for multicycle_control: per-cycle expected outputs from an
// instruction-level model are queued by the driver and checked by a monitor.
module tb_multicycle_control;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw, pcwc, iord, mrd, mwr, m2r, irw;
      logic [1:0] pcs, aluop;
      logic       srca;
      logic [1:0] srcb;
      logic       rw, rdst, done, ill;
   } out_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [5:0] opcode = '0;
   logic       mem_ready = 1'b1;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
   logic [1:0] PCSource, ALUOP, ALUSrcB;
   logic       ALUSrcA, RegWrite, RegDst, instr_done, illegal_op;
   logic [3:0] state;

   out_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   done_seen = 0;
   int   exp_done = 0;
   int   cyc = 0;

   always #5 clock = ~clock;

   multicycle_control #(.MEM_WAIT_EN(1'b1)) dut (
      .clock(clock), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
      .IRWrite(IRWrite), .PCSource(PCSource), .ALUOP(ALUOP),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
      .RegDst(RegDst), .state(state), .instr_done(instr_done),
      .illegal_op(illegal_op)
   );

   function automatic bit legal(input logic [5:0] op);
      return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
   endfunction

   // Expected outputs for one cycle spent in step st of an instruction.
   function automatic out_t model(input int st, input bit rdy, input logic [5:0] op, input bit rst);
      out_t o = '0;
      o.st = 4'(st);
      case (st)
         0:  begin o.mrd = 1; o.srcb = 2'b01; o.pcw = rdy; o.irw = rdy; end
         1:  begin o.srcb = 2'b11; o.ill = !legal(op); o.done = !legal(op); end
         2:  begin o.srca = 1; o.srcb = 2'b10; end
         3:  begin o.mrd = 1; o.iord = 1; end
         4:  begin o.rw = 1; o.m2r = 1; o.done = 1; end
         5:  begin o.iord = 1; o.mwr = 1; o.done = rdy; end
         6:  begin o.srca = 1; o.aluop = 2'b10; end
         7:  begin o.rw = 1; o.rdst = 1; o.done = 1; end
         8:  begin o.srca = 1; o.aluop = 2'b01; o.pcwc = 1; o.pcs = 2'b01; o.done = 1; end
         9:  begin o.pcw = 1; o.pcs = 2'b10; o.done = 1; end
         10: begin o.srca = 1; o.srcb = 2'b10; end
         11: begin o.rw = 1; o.done = 1; end
         default: ;
      endcase
      if (rst) begin
         o.pcw = 0; o.pcwc = 0; o.mrd = 0; o.mwr = 0; o.irw = 0;
         o.rw = 0; o.done = 0; o.ill = 0;
      end
      return o;
   endfunction

   task automatic step(input int st, input bit rdy, input logic [5:0] op, input bit rst);
      @(posedge clock);
      #1;
      reset     = rst;
      mem_ready = rdy;
      opcode    = op;
      sb.push_back(model(st, rdy, op, rst));
   endtask

   function automatic bit rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [5:0] junk();
      return 6'($urandom);
   endfunction

   // One instruction: wf FETCH wait cycles, wm memory wait cycles.
   task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
      for (int i = 0; i < wf; i++) step(0, 1'b0, junk(), 1'b0);
      step(0, 1'b1, junk(), 1'b0);
      step(1, rbit(), op, 1'b0);
      case (op)
         OP_RTYPE: begin step(6, rbit(), op, 1'b0); step(7, rbit(), op, 1'b0); end
         OP_LW: begin
            step(2, rbit(), op, 1'b0);
            for (int i = 0; i < wm; i++) step(3, 1'b0, op, 1'b0);
            step(3, 1'b1, op, 1'b0);
            step(4, rbit(), op, 1'b0);
         end
         OP_SW: begin
            step(2, rbit(), op, 1'b0);
            for (int i = 0; i < wm; i++) step(5, 1'b0, op, 1'b0);
            step(5, 1'b1, op, 1'b0);
         end
         OP_BEQ:  step(8, rbit(), op, 1'b0);
         OP_J:    step(9, rbit(), op, 1'b0);
         OP_ADDI: begin step(10, rbit(), op, 1'b0); step(11, rbit(), op, 1'b0); end
         default: ;
      endcase
      exp_done++;
   endtask

   initial begin : monitor
      out_t act, e;
      forever begin
         @(negedge clock);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            act = {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                   PCSource, ALUOP, ALUSrcA, ALUSrcB, RegWrite, RegDst, instr_done, illegal_op};
            vectors++;
            if (instr_done === 1'b1) done_seen++;
            if (act !== e) begin
               miscompares++;
               $display("FAIL cycle%0d outputs: got state=%0d bus=%h, expected state=%0d bus=%h",
                        cyc, act.st, act, e.st, e);
            end
            cyc++;
         end
      end
   end

   initial begin : stim
      logic [5:0] ops [6];
      logic [5:0] op;
      ops[0] = OP_RTYPE; ops[1] = OP_LW; ops[2] = OP_SW;
      ops[3] = OP_BEQ;   ops[4] = OP_J;  ops[5] = OP_ADDI;

      // Reset seen on two edges, then the first fetch completes immediately.
      step(0, 1'b1, 6'd0, 1'b1);
      run_instr(OP_RTYPE, 0, 0);
      run_instr(OP_LW, 0, 2);
      run_instr(OP_SW, 0, 0);
      run_instr(OP_BEQ, 0, 0);
      run_instr(OP_J, 0, 0);
      run_instr(OP_ADDI, 1, 0);
      run_instr(6'b111111, 0, 0);

      // Abort a store in MEMWR: the reset cycle must not write or complete.
      step(0, 1'b1, junk(), 1'b0);
      step(1, 1'b1, OP_SW, 1'b0);
      step(2, 1'b1, OP_SW, 1'b0);
      step(5, 1'b0, OP_SW, 1'b0);
      step(5, 1'b1, OP_SW, 1'b1);
      run_instr(OP_J, 0, 0);

      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 3) == 0) op = junk();
         else op = ops[$urandom_range(0, 5)];
         run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2));
      end

      @(negedge clock);
      @(negedge clock);
      vectors++;
      if (done_seen != exp_done || sb.size() != 0) begin
         miscompares++;
         $display("FAIL instr_done_count: got %0d pulses (%0d unchecked), expected %0d",
                  done_seen, sb.size(), exp_done);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
